idexe_stage_reg: RTL
====================

# idexe_stage_reg

Parametrised ID→EXE pipeline register for the RV32 core, the successor of the fixed-width ID/EXE latch. It captures operands, immediate, PC, register addresses and a packed control word, supports hold (stall) and bubble insertion (flush) with a per-stage valid bit, and carries the core's performance counters and a stall watchdog. It sits between the decoder/register file and the ALU/forwarding logic.

## Interface
Parameters:
- DATA_W, 32, operand/immediate/PC width
- NUM_OPND, 2, number of source operands
- CTRL_W, 16, packed control-word width (ALUOp, ALUSrc, MemRead, MemWrite, RegWrite, Branch, …)
- CNT_W, 64, performance-counter width
- STALL_MAX, 255, consecutive-stall limit for the watchdog (≥1, fits in 16 bits)

Ports:
- clk  in  1  core clock; every flop is rising-edge
- reset  in  1  asynchronous, active-high; clears every flop
- id_valid  in  1  ID holds a real instruction
- id_pc  in  DATA_W  instruction PC
- id_opnd  in  NUM_OPND*DATA_W  source operand data, operand 0 in LSBs
- id_rs_addr  in  NUM_OPND*5  source register addresses
- id_rd_addr  in  5  destination register
- id_imm  in  DATA_W  immediate
- id_ctrl  in  CTRL_W  control word
- stall  in  1  hold EXE contents
- flush  in  1  kill the instruction entering EXE
- retire  in  1  one instruction retired at WB this cycle
- cnt_clr  in  1  synchronous clear of counters and watchdog
- exe_valid  out  1  EXE holds a real instruction
- exe_pc, exe_opnd, exe_rs_addr, exe_rd_addr, exe_imm, exe_ctrl  out  widths as inputs  registered payload
- cyc_cnt, instret_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters
- stall_err  out  1  sticky watchdog flag

## Operation
- Update priority per cycle: flush > stall > load.
- flush=1: exe_valid←0, all payload fields←0 (bubble), regardless of stall.
- stall=1, flush=0: all EXE outputs hold.
- Otherwise load: if id_valid=1, payload←inputs, exe_valid←1; if id_valid=0, payload←0, exe_valid←0.
- Bubbles are all-zero so exe_ctrl=0 is a guaranteed NOP (no RegWrite/MemWrite).
- Counters (modulo 2^CNT_W, wrap silently to 0):
  - cyc_cnt +1 every cycle.
  - instret_cnt +1 when retire=1.
  - stall_cnt +1 when stall=1 and flush=0.
  - flush_cnt +1 when flush=1 and exe_valid would have loaded a valid instruction (stall=1 or id_valid=1).
- Watchdog: 16-bit run counter +1 per stalled cycle (stall & !flush), reset to 0 on any non-stalled cycle; when the run reaches STALL_MAX, stall_err←1 and stays set; run counter saturates at STALL_MAX.
- cnt_clr=1: all counters, run counter and stall_err←0 that edge; clear wins over a simultaneous increment. Pipeline payload unaffected.

## Timing
- Latency 1 cycle ID→EXE; counters reflect an event the edge after it.
- Reset (async assert, sync-to-clk deassert expected upstream): exe_valid=0, all payload=0, all counters=0, stall_err=0.
- Reset mid-stall or mid-flush: everything cleared immediately; first post-reset edge is a normal load.
- stall and flush together: bubble inserted, stall_cnt and run counter not incremented.
- Run counter at STALL_MAX with further stalls: holds, stall_err stays 1.
- Counter at all-ones plus increment: wraps to 0 with no flag.

## Configuration
- IDEXE_PERF_CNT_EN defined: cyc_cnt, instret_cnt, stall_cnt, flush_cnt implemented as above.
- Undefined: no counter flops; the four counter outputs tied to 0; retire ignored; cnt_clr still clears the watchdog. Pipeline and stall_err behaviour unchanged.

## Test plan
- Reset then 3 loads with id_valid=1, id_pc=0x100/0x104/0x108 → exe_pc 0x100/0x104/0x108 one cycle later each, exe_valid=1, cyc_cnt=3.
- Load pc 0x200, then stall=1 for 4 cycles → exe_pc holds 0x200, stall_cnt=4, run counter 4, stall_err=0 (STALL_MAX=255).
- stall=1 and flush=1 same cycle with EXE valid → exe_valid=0, exe_ctrl=0, flush_cnt=1, stall_cnt unchanged.
- STALL_MAX=3, stall=1 for 3 cycles → stall_err=1 after third edge; stall released → stall_err stays 1; cnt_clr=1 → stall_err=0, all counters 0.
- CNT_W=4, retire=1 for 17 cycles → instret_cnt reads 1 (wrapped); retire=1 with cnt_clr=1 → instret_cnt=0.
- Assert reset mid-stream with exe_pc=0x300 and counters nonzero → outputs 0 immediately, before next clk edge.

Source files
------------

// File: rtl/idexe_stage_reg_if.sv
// ID->EXE stage bus: decoded instruction payload in (id_*), registered payload out (exe_*).
// master = decoder side driving ID fields, slave = the stage register itself.
interface idexe_stage_reg_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_OPND = 2,
  parameter int CTRL_W   = 16
);
  logic                     id_valid;
  logic [DATA_W-1:0]        id_pc;
  logic [NUM_OPND*DATA_W-1:0] id_opnd;
  logic [NUM_OPND*5-1:0]    id_rs_addr;
  logic [4:0]               id_rd_addr;
  logic [DATA_W-1:0]        id_imm;
  logic [CTRL_W-1:0]        id_ctrl;

  logic                     exe_valid;
  logic [DATA_W-1:0]        exe_pc;
  logic [NUM_OPND*DATA_W-1:0] exe_opnd;
  logic [NUM_OPND*5-1:0]    exe_rs_addr;
  logic [4:0]               exe_rd_addr;
  logic [DATA_W-1:0]        exe_imm;
  logic [CTRL_W-1:0]        exe_ctrl;

  modport master (
    output id_valid, id_pc, id_opnd, id_rs_addr, id_rd_addr, id_imm, id_ctrl,
    input  exe_valid, exe_pc, exe_opnd, exe_rs_addr, exe_rd_addr, exe_imm, exe_ctrl
  );

  modport slave (
    input  id_valid, id_pc, id_opnd, id_rs_addr, id_rd_addr, id_imm, id_ctrl,
    output exe_valid, exe_pc, exe_opnd, exe_rs_addr, exe_rd_addr, exe_imm, exe_ctrl
  );
endinterface

// File: rtl/idexe_stage_reg.sv
// ID->EXE pipeline register with stall/flush, stall watchdog and optional performance
// counters (enabled by defining IDEXE_PERF_CNT_EN; otherwise counter outputs read 0).
module idexe_stage_reg #(
  parameter int DATA_W    = 32,
  parameter int NUM_OPND  = 2,
  parameter int CTRL_W    = 16,
  parameter int CNT_W     = 64,
  parameter int STALL_MAX = 255
) (
  input  logic             clk,
  input  logic             reset,
  idexe_stage_reg_if.slave bus,
  input  logic             stall,
  input  logic             flush,
  input  logic             retire,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_err
);
  localparam int          RS_W    = NUM_OPND * 5;
  localparam logic [15:0] RUN_MAX = 16'(STALL_MAX);

  genvar gi;

  logic stalled;     // a genuine hold cycle; flush overrides stall
  logic advance;     // EXE contents change this edge (load or bubble)
  logic take;        // a real instruction enters EXE
  logic flush_kill;  // flush discarded something that would otherwise be valid

  assign stalled    = stall & ~flush;
  assign advance    = flush | ~stall;
  assign take       = ~flush & ~stall & bus.id_valid;
  assign flush_kill = flush & (stall | bus.id_valid);

  logic              valid_reg;
  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] imm_reg;
  logic [RS_W-1:0]   rs_reg;
  logic [4:0]        rd_reg;
  logic [CTRL_W-1:0] ctrl_reg;

  // Anything that is not a taken load becomes an all-zero bubble, so exe_ctrl=0 is a NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      imm_reg   <= '0;
      rs_reg    <= '0;
      rd_reg    <= '0;
      ctrl_reg  <= '0;
    end else if (advance) begin
      valid_reg <= take;
      pc_reg    <= take ? bus.id_pc      : '0;
      imm_reg   <= take ? bus.id_imm     : '0;
      rs_reg    <= take ? bus.id_rs_addr : '0;
      rd_reg    <= take ? bus.id_rd_addr : '0;
      ctrl_reg  <= take ? bus.id_ctrl    : '0;
    end
  end

  generate
    for (gi = 0; gi < NUM_OPND; gi++) begin : g_opnd
      logic [DATA_W-1:0] opnd_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          opnd_reg <= '0;
        else if (advance)
          opnd_reg <= take ? bus.id_opnd[gi*DATA_W +: DATA_W] : '0;
      end
      assign bus.exe_opnd[gi*DATA_W +: DATA_W] = opnd_reg;
    end
  endgenerate

  assign bus.exe_valid   = valid_reg;
  assign bus.exe_pc      = pc_reg;
  assign bus.exe_imm     = imm_reg;
  assign bus.exe_rs_addr = rs_reg;
  assign bus.exe_rd_addr = rd_reg;
  assign bus.exe_ctrl    = ctrl_reg;

  logic [15:0] run_reg;
  logic [15:0] run_next;
  logic        stall_err_reg;
  logic        stall_err_next;

  // Run length saturates at the limit; the error flag is sticky until cnt_clr.
  always_comb begin
    run_next       = '0;
    stall_err_next = stall_err_reg;
    if (cnt_clr) begin
      run_next       = '0;
      stall_err_next = 1'b0;
    end else if (stalled) begin
      run_next = (run_reg == RUN_MAX) ? run_reg : run_reg + 16'd1;
      if (run_next == RUN_MAX)
        stall_err_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_reg       <= '0;
      stall_err_reg <= 1'b0;
    end else begin
      run_reg       <= run_next;
      stall_err_reg <= stall_err_next;
    end
  end

  assign stall_err = stall_err_reg;

`ifdef IDEXE_PERF_CNT_EN
  logic [3:0] cnt_inc;
  assign cnt_inc = {flush_kill, stalled, retire, 1'b1};

  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          cnt_reg <= '0;
        else if (cnt_clr)
          cnt_reg <= '0;
        else if (cnt_inc[gi])
          cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  endgenerate

  assign cyc_cnt     = g_cnt[0].cnt_reg;
  assign instret_cnt = g_cnt[1].cnt_reg;
  assign stall_cnt   = g_cnt[2].cnt_reg;
  assign flush_cnt   = g_cnt[3].cnt_reg;
`else
  logic unused_perf;
  assign unused_perf = retire ^ flush_kill;

  assign cyc_cnt     = '0;
  assign instret_cnt = '0;
  assign stall_cnt   = '0;
  assign flush_cnt   = '0;
`endif

endmodule
